// File: rtl/inst_fetch_pkg.sv
// Shared defines for the instruction-fetch slice: enables, stop flags,
// the default NOP word and the instruction bus widths.
package inst_fetch_pkg;

    localparam logic RstEnable  = 1'b1;
    localparam logic ChipEnable = 1'b1;
    localparam logic Stop       = 1'b1;
    localparam logic NoStop     = 1'b0;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    typedef logic [InstAddrBus-1:0] inst_addr_t;
    typedef logic [InstBus-1:0]     inst_t;

    localparam inst_t NopInst = 32'h0000_0000;

    // A fetch address is word aligned when its two low bits are zero.
    function automatic logic is_word_aligned(input inst_addr_t addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry pc+instruction buffer that parks a fetched word while the
// IF/ID stage is frozen. Clear wins over load.
module if_hold_buf
    import inst_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       clear_i,
    input  inst_addr_t pc_i,
    input  inst_t      inst_i,
    output inst_addr_t pc_o,
    output inst_t      inst_o,
    output logic       valid_o
);

    inst_addr_t pc_q;
    inst_t      inst_q;
    logic       valid_q;

    // Capture on load, invalidate on clear or reset.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pc_q    <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            inst_q  <= inst_i;
            valid_q <= 1'b1;
        end
    end

    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the instruction bus, parks data that
// arrives while IF/ID is frozen, drains in-flight requests after a flush,
// and owns the IF/ID pipeline register.
// Optional feature: define IF_ALIGN_CHECK_EN to add the id_adel output and
// suppress fetches from misaligned addresses.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter inst_t NOP_INST = NopInst
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic [5:0]  stall,
    input  logic        flush,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stallreq_o,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic        id_adel
`endif
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t     state_q, state_d;
    inst_addr_t addr_q, addr_d;
    inst_addr_t id_pc_q, id_pc_d;
    inst_t      id_inst_q, id_inst_d;
    logic       id_valid_q, id_valid_d;
    logic       adel_q, adel_d;

    logic       misalign;
    logic       fetch_req;
    logic       hb_load, hb_clear, hb_valid;
    inst_addr_t hb_pc;
    inst_t      hb_inst;

    // Only the IF/ID and ID stall bits matter to this stage.
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[5:3], stall[0]};

`ifdef IF_ALIGN_CHECK_EN
    assign misalign = (ce_i == ChipEnable) && !is_word_aligned(pc_i);
`else
    assign misalign = 1'b0;
`endif

    assign fetch_req = (ce_i == ChipEnable) && !misalign;

    if_hold_buf u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (hb_load),
        .clear_i (hb_clear),
        .pc_i    (pc_i),
        .inst_i  (bus_rdata),
        .pc_o    (hb_pc),
        .inst_o  (hb_inst),
        .valid_o (hb_valid)
    );

    // Next-state, bus outputs and IF/ID register update.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        adel_d     = adel_q;
        hb_load    = 1'b0;
        hb_clear   = 1'b0;
        bus_req    = 1'b0;
        bus_addr   = pc_i;
        stallreq_o = NoStop;

        case (state_q)
            S_FETCH: begin
                bus_req    = fetch_req;
                bus_addr   = pc_i;
                stallreq_o = fetch_req & ~bus_ack;
                // Remember the outstanding address in case a flush forces a drain.
                if (fetch_req && !bus_ack) addr_d = pc_i;
                if (flush) begin
                    state_d = (fetch_req && !bus_ack) ? S_DISCARD : S_FETCH;
                end else if (fetch_req && bus_ack && (stall[1] == Stop)) begin
                    hb_load = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_d = S_FETCH;
                end else if (stall[1] == NoStop) begin
                    hb_clear = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_DISCARD: begin
                // The bus cannot be abandoned: keep requesting the old address.
                bus_req    = 1'b1;
                bus_addr   = addr_q;
                stallreq_o = Stop;
                if (bus_ack) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (flush) hb_clear = 1'b1;

        if (flush || ((stall[1] == Stop) && (stall[2] == NoStop))) begin
            id_pc_d    = '0;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
            adel_d     = 1'b0;
        end else if (stall[1] == NoStop) begin
            id_pc_d    = '0;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
            adel_d     = 1'b0;
            if (state_q == S_FETCH) begin
                if (misalign) begin
                    id_pc_d = pc_i;
                    adel_d  = 1'b1;
                end else if (fetch_req && bus_ack) begin
                    id_pc_d    = pc_i;
                    id_inst_d  = bus_rdata;
                    id_valid_d = 1'b1;
                end
            end else if (state_q == S_HOLD) begin
                id_pc_d    = hb_pc;
                id_inst_d  = hb_inst;
                id_valid_d = hb_valid;
            end
        end
    end

    // State and IF/ID pipeline registers.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q    <= S_FETCH;
            addr_q     <= '0;
            id_pc_q    <= '0;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
            adel_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            adel_q     <= adel_d;
        end
    end

    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign id_valid = id_valid_q;

`ifdef IF_ALIGN_CHECK_EN
    assign id_adel = adel_q;
`else
    logic unused_adel;
    assign unused_adel = adel_q ^ adel_d;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic [5:0]  stall;
    logic        flush;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stallreq_o;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
`ifdef IF_ALIGN_CHECK_EN
    logic        id_adel;
`endif

    int tests = 0;
    int fails = 0;

    inst_fetch #(.NOP_INST(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_i       (pc_i),
        .ce_i       (ce_i),
        .stall      (stall),
        .flush      (flush),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .stallreq_o (stallreq_o),
        .id_pc      (id_pc),
        .id_inst    (id_inst),
        .id_valid   (id_valid)
`ifdef IF_ALIGN_CHECK_EN
        ,
        .id_adel    (id_adel)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1; ce_i = 1'b0; stall = '0; flush = 1'b0;
        bus_ack = 1'b0; bus_rdata = 32'hFFFF_FFFF; pc_i = 32'h0;
        @(negedge clk); @(negedge clk);
        tests++;
        if (id_pc !== 32'h0 || id_inst !== NOP || id_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_regs: pc=%h inst=%h valid=%b, want pc=0 inst=%h valid=0", id_pc, id_inst, id_valid, NOP);
        end
        tests++;
        if (bus_req !== 1'b0 || stallreq_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_bus: req=%b stallreq=%b, want 0 0", bus_req, stallreq_o);
        end
        $display("[TB] reset checked");
        rst = 1'b0;
    endtask

    task automatic test_zero_wait;
        logic [31:0] pcs [3];
        logic [31:0] dat [3];
        pcs = '{32'h0, 32'h4, 32'h8};
        dat = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
        for (int i = 0; i < 3; i++) begin
            pc_i = pcs[i]; ce_i = 1'b1; bus_ack = 1'b1; bus_rdata = dat[i];
            #1;
            tests++;
            if (bus_req !== 1'b1 || bus_addr !== pcs[i] || stallreq_o !== 1'b0) begin
                fails++;
                $display("FAIL zw_bus%0d: req=%b addr=%h stallreq=%b, want 1 %h 0", i, bus_req, bus_addr, stallreq_o, pcs[i]);
            end
            @(negedge clk);
            tests++;
            if (id_pc !== pcs[i] || id_inst !== dat[i] || id_valid !== 1'b1) begin
                fails++;
                $display("FAIL zw_id%0d: pc=%h inst=%h valid=%b, want %h %h 1", i, id_pc, id_inst, id_valid, pcs[i], dat[i]);
            end
            $display("[TB] zero-wait fetch pc=%h", pcs[i]);
        end
    endtask

    task automatic test_wait_states;
        pc_i = 32'h20; ce_i = 1'b1; bus_ack = 1'b0; bus_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (stallreq_o !== 1'b1 || bus_req !== 1'b1 || bus_addr !== 32'h20) begin
                fails++;
                $display("FAIL wait%0d: stallreq=%b req=%b addr=%h, want 1 1 00000020", i, stallreq_o, bus_req, bus_addr);
            end
            @(negedge clk);
        end
        bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
        #1;
        tests++;
        if (stallreq_o !== 1'b0 || bus_addr !== 32'h20) begin
            fails++;
            $display("FAIL wait_ack: stallreq=%b addr=%h, want 0 00000020", stallreq_o, bus_addr);
        end
        @(negedge clk);
        tests++;
        if (id_pc !== 32'h20 || id_inst !== 32'h1111_2222 || id_valid !== 1'b1) begin
            fails++;
            $display("FAIL wait_id: pc=%h inst=%h valid=%b, want 00000020 11112222 1", id_pc, id_inst, id_valid);
        end
        $display("[TB] 3-wait fetch pc=00000020");
    endtask

    task automatic test_hold;
        pc_i = 32'h30; ce_i = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h8C01_0000; stall = 6'b000110;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = 32'h0;
        #1;
        tests++;
        if (bus_req !== 1'b0 || stallreq_o !== 1'b0) begin
            fails++;
            $display("FAIL hold_bus: req=%b stallreq=%b, want 0 0", bus_req, stallreq_o);
        end
        tests++;
        if (id_pc !== 32'h20 || id_inst !== 32'h1111_2222 || id_valid !== 1'b1) begin
            fails++;
            $display("FAIL hold_keep: pc=%h inst=%h valid=%b, want 00000020 11112222 1", id_pc, id_inst, id_valid);
        end
        @(negedge clk);
        stall = '0;
        @(negedge clk);
        tests++;
        if (id_pc !== 32'h30 || id_inst !== 32'h8C01_0000 || id_valid !== 1'b1) begin
            fails++;
            $display("FAIL hold_release: pc=%h inst=%h valid=%b, want 00000030 8c010000 1", id_pc, id_inst, id_valid);
        end
        $display("[TB] held fetch pc=00000030 released");
    endtask

    task automatic test_bubble;
        pc_i = 32'h34; ce_i = 1'b0; bus_ack = 1'b0; stall = 6'b000010;
        @(negedge clk);
        tests++;
        if (id_pc !== 32'h0 || id_inst !== NOP || id_valid !== 1'b0) begin
            fails++;
            $display("FAIL bubble: pc=%h inst=%h valid=%b, want 0 %h 0", id_pc, id_inst, id_valid, NOP);
        end
        stall = '0;
        $display("[TB] bubble inserted");
    endtask

    task automatic test_ce_off;
        pc_i = 32'h38; ce_i = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h3333_4444;
        @(negedge clk);
        ce_i = 1'b0; bus_ack = 1'b0;
        #1;
        tests++;
        if (bus_req !== 1'b0 || stallreq_o !== 1'b0) begin
            fails++;
            $display("FAIL ce_off_bus: req=%b stallreq=%b, want 0 0", bus_req, stallreq_o);
        end
        @(negedge clk);
        tests++;
        if (id_valid !== 1'b0) begin
            fails++;
            $display("FAIL ce_off_valid: valid=%b, want 0", id_valid);
        end
        $display("[TB] chip-enable off");
    endtask

    task automatic test_discard;
        pc_i = 32'h40; ce_i = 1'b1; bus_ack = 1'b0;
        #1;
        tests++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h40) begin
            fails++;
            $display("FAIL disc_req: req=%b addr=%h, want 1 00000040", bus_req, bus_addr);
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; pc_i = 32'h80;
        #1;
        tests++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h40 || stallreq_o !== 1'b1 || id_valid !== 1'b0) begin
            fails++;
            $display("FAIL disc_state: req=%b addr=%h stallreq=%b valid=%b, want 1 00000040 1 0", bus_req, bus_addr, stallreq_o, id_valid);
        end
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        #1;
        tests++;
        if (bus_addr !== 32'h40 || stallreq_o !== 1'b1) begin
            fails++;
            $display("FAIL disc_ack: addr=%h stallreq=%b, want 00000040 1", bus_addr, stallreq_o);
        end
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        tests++;
        if (id_valid !== 1'b0 || id_inst !== NOP || bus_req !== 1'b1 || bus_addr !== 32'h80) begin
            fails++;
            $display("FAIL disc_drop: valid=%b inst=%h req=%b addr=%h, want 0 %h 1 00000080", id_valid, id_inst, bus_req, bus_addr, NOP);
        end
        bus_ack = 1'b1; bus_rdata = 32'h5555_0000;
        @(negedge clk);
        tests++;
        if (id_pc !== 32'h80 || id_inst !== 32'h5555_0000 || id_valid !== 1'b1) begin
            fails++;
            $display("FAIL disc_next: pc=%h inst=%h valid=%b, want 00000080 55550000 1", id_pc, id_inst, id_valid);
        end
        $display("[TB] flushed request discarded, refetch pc=00000080");
    endtask

    task automatic test_flush_on_ack;
        pc_i = 32'h60; ce_i = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h6666_0000; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; bus_ack = 1'b0; pc_i = 32'h64;
        #1;
        tests++;
        if (id_valid !== 1'b0 || id_inst !== NOP || bus_addr !== 32'h64 || bus_req !== 1'b1) begin
            fails++;
            $display("FAIL flush_ack: valid=%b inst=%h addr=%h req=%b, want 0 %h 00000064 1", id_valid, id_inst, bus_addr, bus_req, NOP);
        end
        $display("[TB] flush with ack dropped data");
    endtask

    task automatic test_reset_mid_request;
        pc_i = 32'h90; ce_i = 1'b1; bus_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; ce_i = 1'b0;
        #1;
        tests++;
        if (bus_req !== 1'b0 || stallreq_o !== 1'b0 || id_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: req=%b stallreq=%b valid=%b, want 0 0 0", bus_req, stallreq_o, id_valid);
        end
        @(negedge clk);
        $display("[TB] reset mid-request");
    endtask

`ifdef IF_ALIGN_CHECK_EN
    task automatic test_align;
        pc_i = 32'h102; ce_i = 1'b1; bus_ack = 1'b0;
        #1;
        tests++;
        if (bus_req !== 1'b0) begin
            fails++;
            $display("FAIL align_req: req=%b, want 0", bus_req);
        end
        @(negedge clk);
        tests++;
        if (id_adel !== 1'b1 || id_pc !== 32'h102 || id_valid !== 1'b0 || id_inst !== NOP) begin
            fails++;
            $display("FAIL align_id: adel=%b pc=%h valid=%b inst=%h, want 1 00000102 0 %h", id_adel, id_pc, id_valid, id_inst, NOP);
        end
        pc_i = 32'h104; bus_ack = 1'b1; bus_rdata = 32'h7777_0000;
        @(negedge clk);
        tests++;
        if (id_adel !== 1'b0 || id_pc !== 32'h104) begin
            fails++;
            $display("FAIL align_clear: adel=%b pc=%h, want 0 00000104", id_adel, id_pc);
        end
        bus_ack = 1'b0;
        $display("[TB] misaligned fetch pc=00000102");
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_hold();
        test_bubble();
        test_ce_off();
        test_discard();
        test_flush_on_ack();
        test_reset_mid_request();
`ifdef IF_ALIGN_CHECK_EN
        test_align();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
